// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register bank geometry, register index constants
// for the 4-to-16 select decoders, and the one-hot legality helper.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    // Register index encoding used by the read/write select decoders.
    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t R0  = 4'd0;
    localparam reg_idx_t R1  = 4'd1;
    localparam reg_idx_t R2  = 4'd2;
    localparam reg_idx_t R3  = 4'd3;
    localparam reg_idx_t R4  = 4'd4;
    localparam reg_idx_t R5  = 4'd5;
    localparam reg_idx_t R6  = 4'd6;
    localparam reg_idx_t R7  = 4'd7;
    localparam reg_idx_t R8  = 4'd8;
    localparam reg_idx_t R9  = 4'd9;
    localparam reg_idx_t R10 = 4'd10;
    localparam reg_idx_t R11 = 4'd11;
    localparam reg_idx_t R12 = 4'd12;
    localparam reg_idx_t R13 = 4'd13;
    localparam reg_idx_t R14 = 4'd14;
    localparam reg_idx_t R15 = 4'd15;

    // True when at most one bit of the select vector is set.
    function automatic logic is_onehot_or_zero(input logic [15:0] v);
        return (v & (v - 16'd1)) == 16'd0;
    endfunction

endpackage

// File: rtl/reg32_en.sv
// Single bank register: async active-low clear, synchronous load enable.
module reg32_en
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Load d when enabled; clear forces zero at any time.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_16x32.sv
// 16 x 32-bit register bank fed by one-hot read/write select vectors.
// Multi-hot selects are rejected and latched into a sticky error flag.
// Reads of R0 with ba_out set return zero (base-address rule).
// Optional macro REG_BANK_BYPASS_EN: a same-cycle write and read of the same
// register returns the incoming bus_in value (write-through); without it the
// read returns the old register contents.
module reg_bank_16x32
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_REGS-1:0] wr_sel,
    input  logic [NUM_REGS-1:0] rd_sel,
    input  logic                ba_out,
    input  logic [DATA_W-1:0]   bus_in,
    output logic [DATA_W-1:0]   bus_out,
    output logic                rd_valid,
    output logic                sel_err,
    output logic [NUM_REGS-1:0] written
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_en;
    logic [DATA_W-1:0]   rd_data;
    logic                wr_ok;
    logic                rd_ok;
    logic                rd_go;

    // Legality: zero or one bit set; a read is issued only with exactly one.
    always_comb begin
        wr_ok = is_onehot_or_zero(wr_sel);
        rd_ok = is_onehot_or_zero(rd_sel);
        rd_go = rd_ok && (rd_sel != '0);
        wr_en = wr_ok ? wr_sel : '0;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_reg
            reg32_en u_reg (
                .clock (clock),
                .clear (clear),
                .en    (wr_en[g]),
                .d     (bus_in),
                .q     (regs[g])
            );
        end
    endgenerate

    // AND-OR read mux over the one-hot select, then bypass and R0 override.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel[i]) begin
                rd_data = rd_data | regs[i];
            end
        end
`ifdef REG_BANK_BYPASS_EN
        if (wr_ok && ((wr_sel & rd_sel) != '0)) begin
            rd_data = bus_in;
        end
`endif
        if (ba_out && rd_sel[R0]) begin
            rd_data = '0;
        end
    end

    // Registered read result; bus_out holds when no legal read is issued.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_out  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                bus_out <= rd_data;
            end
        end
    end

    // Sticky select error and written-since-reset map.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sel_err <= 1'b0;
            written <= '0;
        end else begin
            sel_err <= sel_err | ~wr_ok | ~rd_ok;
            written <= written | wr_en;
        end
    end

endmodule
